// File: rtl/key_debounce_edge.sv
// Four-key debouncer: 2-flop sync, per-key qualify counter, registered press/release pulses.
// Define KEY_AUTOREPEAT_EN to add per-key auto-repeat on key_press; latency key->outputs is 2 + 2**debounce_depth edges.
module key_debounce_edge #(
  parameter int debounce_depth      = 16,
  parameter int repeat_delay_width  = 24,
  parameter int repeat_period_width = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  output logic [3:0] key_stable,
  output logic [3:0] key_press,
  output logic [3:0] key_release
);

  if (debounce_depth < 1 || repeat_delay_width < 1 || repeat_period_width < 1) begin : g_bad_param
    $error("key_debounce_edge: counter widths must be at least 1");
  end

  logic [3:0]                sync1;
  logic [3:0]                sample;
  logic [debounce_depth-1:0] cnt [4];
  logic [3:0]                accept;
  logic [3:0]                fire;

  // accept marks the cycle where a sample has differed for 2**debounce_depth samples
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (sample[i] != key_stable[i]) && (cnt[i] == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sample      <= '0;
      key_stable  <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1       <= key;
      sample      <= sync1;
      key_press   <= (accept & ~key_stable) | fire;
      key_release <= accept & key_stable;
      for (int i = 0; i < 4; i++) begin
        if (sample[i] == key_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == '1) begin
          cnt[i]        <= '0;
          key_stable[i] <= sample[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  rpt_state_t                     rstate     [4];
  rpt_state_t                     rstate_nxt [4];
  logic [repeat_delay_width-1:0]  dcnt       [4];
  logic [repeat_delay_width-1:0]  dcnt_nxt   [4];
  logic [repeat_period_width-1:0] pcnt       [4];
  logic [repeat_period_width-1:0] pcnt_nxt   [4];

  // A release accepted in the same cycle always wins over a pending repeat pulse
  always_comb begin
    fire = '0;
    for (int i = 0; i < 4; i++) begin
      rstate_nxt[i] = rstate[i];
      dcnt_nxt[i]   = dcnt[i];
      pcnt_nxt[i]   = pcnt[i];
      case (rstate[i])
        IDLE: begin
          if (accept[i] && !key_stable[i]) begin
            rstate_nxt[i] = DELAY;
            dcnt_nxt[i]   = '0;
          end
        end
        DELAY: begin
          if (accept[i] && key_stable[i]) begin
            rstate_nxt[i] = IDLE;
            dcnt_nxt[i]   = '0;
          end else if (dcnt[i] == '1) begin
            fire[i]       = 1'b1;
            rstate_nxt[i] = REPEAT;
            dcnt_nxt[i]   = '0;
            pcnt_nxt[i]   = '0;
          end else begin
            dcnt_nxt[i] = dcnt[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (accept[i] && key_stable[i]) begin
            rstate_nxt[i] = IDLE;
            pcnt_nxt[i]   = '0;
          end else if (pcnt[i] == '1) begin
            fire[i]     = 1'b1;
            pcnt_nxt[i] = '0;
          end else begin
            pcnt_nxt[i] = pcnt[i] + 1'b1;
          end
        end
        default: begin
          rstate_nxt[i] = IDLE;
          dcnt_nxt[i]   = '0;
          pcnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        rstate[i] <= IDLE;
        dcnt[i]   <= '0;
        pcnt[i]   <= '0;
      end else begin
        rstate[i] <= rstate_nxt[i];
        dcnt[i]   <= dcnt_nxt[i];
        pcnt[i]   <= pcnt_nxt[i];
      end
    end
  end
`else
  assign fire = '0;
`endif

endmodule

// File: doc/key_debounce_edge.md
KEY_DEBOUNCE_EDGE -- requirements
Module: key_debounce_edge

Interface
REQ-001 Parameter: debounce_depth, default 16, debounce counter width; a change is accepted after 2**debounce_depth consecutive differing samples.
REQ-002 Parameter: repeat_delay_width, default 24, auto-repeat first-delay counter width (used only with KEY_AUTOREPEAT_EN).
REQ-003 Parameter: repeat_period_width, default 22, auto-repeat period counter width (used only with KEY_AUTOREPEAT_EN).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: key  input  4  raw asynchronous push-button levels, 1 = pressed.
REQ-007 Port: key_stable  output  4  debounced level per key.
REQ-008 Port: key_press  output  4  one-cycle pulse per key on accepted press (and on auto-repeat when enabled).
REQ-009 Port: key_release  output  4  one-cycle pulse per key on accepted release.

Function
REQ-010 Each key bit SHALL pass through a 2-flop synchronizer before any other logic; the second flop output is the "sample".
REQ-011 Each key SHALL own an independent counter of debounce_depth bits; the 4 keys SHALL never interact.
REQ-012 Sample equal to key_stable -> counter cleared to 0.
REQ-013 Sample differing, counter < 2**debounce_depth-1 -> counter increments by 1.
REQ-014 Sample differing, counter == 2**debounce_depth-1 -> key_stable takes the sample value, counter cleared; no wrap-around of the counter otherwise.
REQ-015 A single equal sample during counting SHALL restart qualification from 0 (glitch rejection).
REQ-016 key_press[i] SHALL be 1 for exactly the cycle in which key_stable[i] first reads 1 after being 0; key_release[i] likewise for 1->0.
REQ-017 Latency: a clean edge on key held stable appears on key_stable and the pulse output 2 + 2**debounce_depth rising edges after the first edge that samples it.
REQ-018 key_press[i] and key_release[i] SHALL never be 1 in the same cycle.
REQ-019 All outputs SHALL be registered; no combinational path from key to any output.

Reset
REQ-020 While reset is 1: synchronizer flops, counters, key_stable, key_press, key_release all 0; auto-repeat state IDLE with counters 0.
REQ-021 Reset asserted mid-qualification or mid-repeat SHALL abort it; no pulse SHALL be emitted in the cycle reset is asserted or in the first cycle after deassertion.
REQ-022 A key held pressed through reset SHALL be re-qualified from 0 after deassertion and then produce one key_press pulse.

Configuration
REQ-023 Macro KEY_AUTOREPEAT_EN, when defined, SHALL compile in a per-key auto-repeat FSM; when undefined, no repeat logic exists, key_press pulses only per REQ-016, and repeat parameters are ignored.
REQ-024 FSM states: IDLE (key_stable=0), DELAY, REPEAT; IDLE->DELAY on accepted press, repeat counter cleared.
REQ-025 DELAY: counter counts every cycle; after 2**repeat_delay_width cycles -> one key_press pulse, go REPEAT, counter cleared.
REQ-026 REPEAT: one key_press pulse every 2**repeat_period_width cycles while key_stable=1.
REQ-027 Accepted release in DELAY or REPEAT -> IDLE immediately, counter cleared, no repeat pulse in that cycle (key_release has priority).

Verification (bench uses debounce_depth=2, repeat_delay_width=3, repeat_period_width=2)
REQ-028 Reset then key=4'b0001 held -> key_stable=4'b0001 and key_press=4'b0001 for one cycle, 6 edges after key first sampled; key_release stays 0.
REQ-029 key[0] pressed 3 cycles, released 1 cycle, pressed again -> no pulse until 4 consecutive differing samples after the gap; exactly one key_press.
REQ-030 key=4'b1010 from 4'b0101 (all stable 4'b0101) -> same cycle key_press=4'b1010, key_release=4'b0101, key_stable=4'b1010.
REQ-031 Reset asserted 2 cycles into qualification of key[3] held 1 -> all outputs 0; after deassertion key_press[3] pulses once, 6 edges later.
REQ-032 With KEY_AUTOREPEAT_EN, key[2] held -> key_press[2] at accept, +8 cycles, then every 4 cycles; release -> key_release[2] once, pulses stop.
REQ-033 Random key every cycle for 100000 cycles -> REQ-018 never violated, every key_press/key_release pulse exactly 1 cycle wide.
